// File: rtl/multicycle_mips_core.sv
// Multicycle MIPS subset core: FSM sequencer plus datapath behind one shared
// instruction/data memory port with a req/ready handshake.
module multicycle_mips_core #(
  parameter logic [31:0] RESET_PC      = 32'h0,
  parameter int          ADDRESS_WIDTH = 5,
  parameter bit          ENABLE_BNE    = 1'b0
) (
  input  logic        CLK,
  input  logic        Reset,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic [31:0] PC,
  output logic        Halted
);
  localparam int NREG = 1 << ADDRESS_WIDTH;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_EXEC, S_ALUWB, S_MEMADR, S_MEMRD, S_MEMWB,
    S_MEMWR, S_BRANCH, S_ADDIEX, S_ADDIWB, S_JUMP, S_HALT
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d, ir_q, ir_d, a_q, a_d, b_q, b_d;
  logic [31:0] alu_q, alu_d, mdr_q, mdr_d;
  logic [31:0] rf_q [NREG];

  logic                     rf_we;
  logic [ADDRESS_WIDTH-1:0] rf_waddr;
  logic [31:0]              rf_wdata;
  logic                     req, we;
  logic [31:0]              addr;

  logic [5:0]               opcode, funct;
  logic [ADDRESS_WIDTH-1:0] rs, rt, rd;
  logic [31:0]              imm;
  logic                     unused_ir;

  assign opcode    = ir_q[31:26];
  assign funct     = ir_q[5:0];
  assign rs        = ir_q[21 +: ADDRESS_WIDTH];
  assign rt        = ir_q[16 +: ADDRESS_WIDTH];
  assign rd        = ir_q[11 +: ADDRESS_WIDTH];
  assign imm       = {{16{ir_q[15]}}, ir_q[15:0]};
  assign unused_ir = ^ir_q;

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ir_d     = ir_q;
    a_d      = a_q;
    b_d      = b_q;
    alu_d    = alu_q;
    mdr_d    = mdr_q;
    rf_we    = 1'b0;
    rf_waddr = '0;
    rf_wdata = '0;
    req      = 1'b0;
    we       = 1'b0;
    addr     = pc_q;
    case (state_q)
      S_FETCH: begin
        req = 1'b1;
        if (mem_ready) begin
          ir_d    = mem_rdata;
          pc_d    = pc_q + 32'd4;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        a_d   = rf_q[rs];
        b_d   = rf_q[rt];
        alu_d = pc_q + (imm << 2);
        case (opcode)
          OP_RTYPE:      state_d = S_EXEC;
          OP_LW, OP_SW:  state_d = S_MEMADR;
          OP_BEQ:        state_d = S_BRANCH;
          OP_BNE:        state_d = ENABLE_BNE ? S_BRANCH : S_HALT;
          OP_ADDI:       state_d = S_ADDIEX;
          OP_J:          state_d = S_JUMP;
          default:       state_d = S_HALT;
        endcase
      end
      S_EXEC: begin
        state_d = S_ALUWB;
        case (funct)
          FN_ADD:  alu_d = a_q + b_q;
          FN_SUB:  alu_d = a_q - b_q;
          FN_AND:  alu_d = a_q & b_q;
          FN_OR:   alu_d = a_q | b_q;
          FN_SLT:  alu_d = ($signed(a_q) < $signed(b_q)) ? 32'd1 : 32'd0;
          default: state_d = S_HALT;
        endcase
      end
      S_ALUWB: begin
        rf_we    = 1'b1;
        rf_waddr = rd;
        rf_wdata = alu_q;
        state_d  = S_FETCH;
      end
      S_MEMADR: begin
        alu_d   = a_q + imm;
        state_d = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        req  = 1'b1;
        addr = alu_q;
        if (mem_ready) begin
          mdr_d   = mem_rdata;
          state_d = S_MEMWB;
        end
      end
      S_MEMWB: begin
        rf_we    = 1'b1;
        rf_waddr = rt;
        rf_wdata = mdr_q;
        state_d  = S_FETCH;
      end
      S_MEMWR: begin
        req  = 1'b1;
        we   = 1'b1;
        addr = alu_q;
        if (mem_ready) state_d = S_FETCH;
      end
      S_BRANCH: begin
        if ((opcode == OP_BEQ) ? (a_q == b_q) : (a_q != b_q)) pc_d = alu_q;
        state_d = S_FETCH;
      end
      S_ADDIEX: begin
        alu_d   = a_q + imm;
        state_d = S_ADDIWB;
      end
      S_ADDIWB: begin
        rf_we    = 1'b1;
        rf_waddr = rt;
        rf_wdata = alu_q;
        state_d  = S_FETCH;
      end
      S_JUMP: begin
        // pc_q already points past the jump, so the region bits come from PC+4
        pc_d    = {pc_q[31:28], ir_q[25:0], 2'b00};
        state_d = S_FETCH;
      end
      default: state_d = S_HALT;
    endcase
  end

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      pc_q  <= RESET_PC;
      ir_q  <= '0;
      a_q   <= '0;
      b_q   <= '0;
      alu_q <= '0;
      mdr_q <= '0;
    end else begin
      pc_q  <= pc_d;
      ir_q  <= ir_d;
      a_q   <= a_d;
      b_q   <= b_d;
      alu_q <= alu_d;
      mdr_q <= mdr_d;
    end
  end

  // Register 0 is never written, so its reset value keeps it reading zero.
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
    end else if (rf_we && (rf_waddr != '0)) begin
      rf_q[rf_waddr] <= rf_wdata;
    end
  end

  // Gating with Reset drops a pending request asynchronously.
  assign mem_req   = Reset & req;
  assign mem_we    = Reset & we;
  assign mem_addr  = Reset ? {addr[31:2], 2'b00} : 32'h0;
  assign mem_wdata = (Reset & we) ? b_q : 32'h0;
  assign PC        = pc_q;
  assign Halted    = Reset & (state_q == S_HALT);

endmodule

// File: tb/tb_multicycle_mips_core.sv
// Directed bench for multicycle_mips_core: one bne-enabled core on a word memory
// model, plus a bne-disabled core fed a constant bne word.
module tb_multicycle_mips_core;
  logic        CLK = 1'b0;
  logic        Reset = 1'b0;
  logic        mem_req, mem_we, mem_ready, Halted;
  logic [31:0] mem_addr, mem_wdata, mem_rdata, PC;
  logic        req0, we0, halt0;
  logic [31:0] addr0, wdata0, pc0;

  logic [31:0] mem [64];
  int          n_assert = 0;
  int          n_fail = 0;
  int          wr_cnt = 0;
  int          wr_base;
  logic [31:0] wr_addr = '0;
  logic [31:0] wr_data = '0;

  always #5 CLK = ~CLK;

  multicycle_mips_core #(.RESET_PC(32'h0), .ADDRESS_WIDTH(5), .ENABLE_BNE(1'b1)) u_dut (
    .CLK(CLK), .Reset(Reset), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready), .PC(PC), .Halted(Halted));

  // bne $0,$1,+2 on every address
  multicycle_mips_core #(.RESET_PC(32'h0), .ADDRESS_WIDTH(5), .ENABLE_BNE(1'b0)) u_dut0 (
    .CLK(CLK), .Reset(Reset), .mem_req(req0), .mem_we(we0), .mem_addr(addr0),
    .mem_wdata(wdata0), .mem_rdata(32'h1401_0002), .mem_ready(1'b1), .PC(pc0), .Halted(halt0));

  assign mem_rdata = mem[mem_addr[7:2]];

  always @(posedge CLK) begin
    if (mem_req && mem_we && mem_ready) begin
      mem[mem_addr[7:2]] = mem_wdata;
      wr_cnt  = wr_cnt + 1;
      wr_addr = mem_addr;
      wr_data = mem_wdata;
    end
  end

  function automatic logic [31:0] f_i(input logic [5:0] op, input int rs, input int rt, input int imm);
    return {op, rs[4:0], rt[4:0], imm[15:0]};
  endfunction

  function automatic logic [31:0] f_r(input int rd, input int rs, input int rt, input logic [5:0] fn);
    return {6'b000000, rs[4:0], rt[4:0], rd[4:0], 5'b00000, fn};
  endfunction

  function automatic logic [31:0] f_j(input int tgt);
    return {6'b000010, tgt[25:0]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 64; i++) mem[i] = 32'hA5A5_A5A5;
  endtask

  task automatic enter_reset();
    @(negedge CLK);
    Reset = 1'b0;
    #2;
  endtask

  task automatic release_reset();
    @(negedge CLK);
    Reset = 1'b1;
    #1;
  endtask

  localparam logic [5:0] ADDI = 6'b001000, LW = 6'b100011, SW = 6'b101011;
  localparam logic [5:0] BEQ = 6'b000100, BNE = 6'b000101;

  initial begin
    mem_ready = 1'b1;
    clear_mem();
    #2;
    chk("rst_req", {31'b0, mem_req}, 32'd0);
    chk("rst_we", {31'b0, mem_we}, 32'd0);
    chk("rst_addr", mem_addr, 32'd0);
    chk("rst_wdata", mem_wdata, 32'd0);
    chk("rst_halted", {31'b0, Halted}, 32'd0);
    chk("rst_pc", PC, 32'd0);
    chk("rst_dut0_we_wdata", {we0, wdata0[30:0]}, 32'd0);

    // addi/addi/add/sw, zero-wait
    mem[0] = f_i(ADDI, 0, 1, 5);
    mem[1] = f_i(ADDI, 0, 2, 7);
    mem[2] = f_r(3, 1, 2, 6'b100000);
    mem[3] = f_i(SW, 0, 3, 0);
    mem[4] = f_j(4);
    wr_base = wr_cnt;
    release_reset();
    chk("a_first_req", {31'b0, mem_req}, 32'd1);
    chk("a_first_addr", mem_addr, 32'd0);
    step(1);
    chk("a_decode_pc", PC, 32'd4);
    chk("a_decode_req", {31'b0, mem_req}, 32'd0);
    step(13);
    chk("a_no_write_yet", {31'b0, mem_we}, 32'd0);
    step(1);
    chk("a_sw_we_c15", {31'b0, mem_we}, 32'd1);
    chk("a_sw_addr", mem_addr, 32'd0);
    chk("a_sw_wdata", mem_wdata, 32'd12);
    step(1);
    chk("a_wr_cnt", wr_cnt - wr_base, 32'd1);
    chk("a_mem0", mem[0], 32'd12);
    chk("a_next_fetch", mem_addr, 32'd16);

    // fetch wait states then lw/sw
    enter_reset();
    clear_mem();
    mem[0] = f_i(LW, 0, 5, 32);
    mem[1] = f_i(SW, 0, 5, 36);
    mem[2] = f_j(2);
    mem[8] = 32'hDEAD_BEEF;
    mem_ready = 1'b0;
    release_reset();
    chk("b_req0", {31'b0, mem_req}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      step(1);
      chk("b_wait_req", {31'b0, mem_req}, 32'd1);
      chk("b_wait_addr", mem_addr, 32'd0);
      chk("b_wait_pc", PC, 32'd0);
    end
    mem_ready = 1'b1;
    step(1);
    chk("b_decode_pc", PC, 32'd4);
    step(2);
    chk("b_memrd_req", {mem_we, mem_req}, 32'd1);
    chk("b_memrd_addr", mem_addr, 32'd32);
    step(2);
    chk("b_lw_done_8cyc_addr", mem_addr, 32'd4);
    chk("b_lw_done_req", {31'b0, mem_req}, 32'd1);
    step(4);
    chk("b_sw_addr", wr_addr, 32'd36);
    chk("b_sw_data", wr_data, 32'hDEAD_BEEF);

    // beq/bne taken and not taken
    enter_reset();
    clear_mem();
    mem[0]  = f_i(ADDI, 0, 1, 3);
    mem[1]  = f_i(ADDI, 0, 2, 3);
    mem[2]  = f_i(BEQ, 1, 2, 2);
    mem[5]  = f_i(BEQ, 1, 0, 2);
    mem[6]  = f_i(BNE, 1, 0, 2);
    mem[9]  = f_i(BNE, 1, 2, 2);
    mem[10] = f_j(10);
    release_reset();
    step(10);
    chk("c_branch_pc", PC, 32'd12);
    step(1);
    chk("c_beq_taken", mem_addr, 32'd20);
    step(3);
    chk("c_beq_not_taken", mem_addr, 32'd24);
    step(3);
    chk("c_bne_taken", mem_addr, 32'd36);
    step(3);
    chk("c_bne_not_taken", mem_addr, 32'd40);
    step(3);
    chk("c_jump_pc", PC, 32'd40);
    chk("c_jump_addr", mem_addr, 32'd40);

    // r0 write-protect and ALU ops
    enter_reset();
    clear_mem();
    mem[0]  = f_i(ADDI, 0, 0, 9);
    mem[1]  = f_r(4, 0, 0, 6'b100000);
    mem[2]  = f_i(ADDI, 0, 7, -1);
    mem[3]  = f_i(ADDI, 0, 8, 1);
    mem[4]  = f_r(9, 7, 8, 6'b101010);
    mem[5]  = f_r(10, 8, 7, 6'b101010);
    mem[6]  = f_r(11, 8, 7, 6'b100010);
    mem[7]  = f_r(12, 7, 8, 6'b100100);
    mem[8]  = f_r(13, 7, 8, 6'b100101);
    mem[9]  = f_i(SW, 0, 4, 128);
    mem[10] = f_i(SW, 0, 9, 132);
    mem[11] = f_i(SW, 0, 10, 136);
    mem[12] = f_i(SW, 0, 11, 140);
    mem[13] = f_i(SW, 0, 12, 144);
    mem[14] = f_i(SW, 0, 13, 148);
    mem[15] = f_j(15);
    release_reset();
    step(64);
    chk("d_r0_protect", mem[32], 32'd0);
    chk("d_slt_neg", mem[33], 32'd1);
    chk("d_slt_pos", mem[34], 32'd0);
    chk("d_sub", mem[35], 32'd2);
    chk("d_and", mem[36], 32'd1);
    chk("d_or", mem[37], 32'hFFFF_FFFF);
    chk("d_spin_pc", PC, 32'd64);

    // reset during a stalled store
    enter_reset();
    clear_mem();
    mem[0] = f_i(ADDI, 0, 3, 77);
    mem[1] = f_i(SW, 0, 3, 128);
    mem[2] = f_j(2);
    release_reset();
    step(6);
    mem_ready = 1'b0;
    step(1);
    chk("e_memwr_we", {mem_we, mem_req}, 32'd3);
    chk("e_memwr_addr", mem_addr, 32'd128);
    chk("e_memwr_data", mem_wdata, 32'd77);
    step(1);
    chk("e_stall_addr", mem_addr, 32'd128);
    chk("e_stall_data", mem_wdata, 32'd77);
    wr_base = wr_cnt;
    #2;
    Reset = 1'b0;
    #1;
    chk("e_abort_req", {mem_we, mem_req}, 32'd0);
    chk("e_abort_addr", mem_addr, 32'd0);
    chk("e_abort_wdata", mem_wdata, 32'd0);
    chk("e_abort_pc", PC, 32'd0);
    mem[0] = f_i(SW, 0, 3, 132);
    mem[1] = f_j(1);
    mem_ready = 1'b1;
    release_reset();
    chk("e_refetch_addr", mem_addr, 32'd0);
    step(4);
    chk("e_reg_cleared", mem[33], 32'd0);
    chk("e_no_abort_write", mem[32], 32'hA5A5_A5A5);
    chk("e_wr_cnt", wr_cnt - wr_base, 32'd1);

    // illegal opcode halt; bne illegal on the second core
    enter_reset();
    clear_mem();
    mem[0] = 32'hFC00_0000;
    release_reset();
    step(1);
    chk("f_decode_halted", {31'b0, Halted}, 32'd0);
    chk("f0_decode_halted", {31'b0, halt0}, 32'd0);
    step(1);
    chk("f_halted", {31'b0, Halted}, 32'd1);
    chk("f_pc", PC, 32'd4);
    chk("f0_halted", {31'b0, halt0}, 32'd1);
    chk("f0_pc", pc0, 32'd4);
    step(5);
    chk("f_still_halted", {31'b0, Halted}, 32'd1);
    chk("f_req_low", {31'b0, mem_req}, 32'd0);
    chk("f_pc_frozen", PC, 32'd4);
    chk("f0_req_low", {31'b0, req0}, 32'd0);
    chk("f0_addr", addr0, addr0 & 32'hFFFF_FFFC);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
